// File: rtl/pipe_pkg.sv
// Shared opcode map, ID/EX control words, FSM encoding and opcode-class helpers
// for the IF/ID/EX/WB pipeline hazard controller.
package pipe_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned CTRL_W = 16;

   localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
   localparam logic [OP_W-1:0] OP_LI   = 6'b000010;
   localparam logic [OP_W-1:0] OP_MOVE = 6'b000011;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b000100;
   localparam logic [OP_W-1:0] OP_SLL  = 6'b000101;
   localparam logic [OP_W-1:0] OP_SRL  = 6'b000110;
   localparam logic [OP_W-1:0] OP_AND  = 6'b000111;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b001000;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b001001;
   localparam logic [OP_W-1:0] OP_OR   = 6'b001010;
   localparam logic [OP_W-1:0] OP_XOR  = 6'b001011;
   localparam logic [OP_W-1:0] OP_MUL  = 6'b001100;
   localparam logic [OP_W-1:0] OP_HALT = 6'b001101;
   localparam logic [OP_W-1:0] OP_NOP  = 6'b001110;

   // One-hot ID/EX control words; NOP is what a bubble loads.
   localparam logic [CTRL_W-1:0] CTRL_ADD  = 16'h0001;
   localparam logic [CTRL_W-1:0] CTRL_SUB  = 16'h0002;
   localparam logic [CTRL_W-1:0] CTRL_LI   = 16'h0004;
   localparam logic [CTRL_W-1:0] CTRL_MOVE = 16'h0008;
   localparam logic [CTRL_W-1:0] CTRL_ADDI = 16'h0010;
   localparam logic [CTRL_W-1:0] CTRL_SLL  = 16'h0020;
   localparam logic [CTRL_W-1:0] CTRL_SRL  = 16'h0040;
   localparam logic [CTRL_W-1:0] CTRL_AND  = 16'h0080;
   localparam logic [CTRL_W-1:0] CTRL_BEQ  = 16'h0100;
   localparam logic [CTRL_W-1:0] CTRL_BNE  = 16'h0200;
   localparam logic [CTRL_W-1:0] CTRL_OR   = 16'h0400;
   localparam logic [CTRL_W-1:0] CTRL_XOR  = 16'h0800;
   localparam logic [CTRL_W-1:0] CTRL_MUL  = 16'h1000;
   localparam logic [CTRL_W-1:0] CTRL_HALT = 16'h2000;
   localparam logic [CTRL_W-1:0] CTRL_NOP  = 16'h4000;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_STALL  = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   function automatic logic op_writes_rd(input logic [OP_W-1:0] op);
      return (op <= OP_MUL) && (op != OP_BEQ) && (op != OP_BNE);
   endfunction

   function automatic logic op_reads_rs(input logic [OP_W-1:0] op);
      return (op_writes_rd(op) && (op != OP_LI)) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   function automatic logic op_reads_rt(input logic [OP_W-1:0] op);
      return op_reads_rs(op) && (op != OP_MOVE) && (op != OP_ADDI);
   endfunction

   // Control word for an opcode; undefined opcodes behave as NOP.
   function automatic logic [CTRL_W-1:0] op_ctrl(input logic [OP_W-1:0] op);
      logic [CTRL_W-1:0] ctrl;
      ctrl = CTRL_NOP;
      if (op <= OP_HALT) ctrl = CTRL_W'(1) << op;
      return ctrl;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue of
// a writer, cleared on write-back, with a sticky flag for unexpected write-backs.
module reg_scoreboard
   import pipe_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_idx,
   input  logic [REG_W-1:0] rs_idx,
   input  logic [REG_W-1:0] rt_idx,
   input  logic [REG_W-1:0] rd_idx,
   output logic             rs_pend,
   output logic             rt_pend,
   output logic             rd_pend,
   output logic             any_pend,
   output logic             sb_err
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_next;

   // Set is applied after clear so a same-index collision leaves the bit set.
   always_comb begin
      pending_next = pending;
      if (clr_en) pending_next[clr_idx] = 1'b0;
      if (set_en) pending_next[set_idx] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= '0;
         sb_err  <= 1'b0;
      end else begin
         pending <= pending_next;
         if (clr_en && !pending[clr_idx]) sb_err <= 1'b1;
      end
   end

   assign rs_pend  = pending[rs_idx];
   assign rt_pend  = pending[rt_idx];
   assign rd_pend  = pending[rd_idx];
   assign any_pend = |pending;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-side sequencing controller: RAW/WAW stalls from the scoreboard, wrong-path
// squash on taken branches, and drain-to-halt on HALT.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [5:0]       id_op,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             wb_en,
   input  logic [4:0]       wb_rd,
   input  logic             branch_taken,
   output logic             issue,
   output logic             pc_stall,
   output logic             if_id_hold,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             halted,
   output logic             sb_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int unsigned        FLUSH_W    = 3;
   localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

   state_t             state;
   state_t             state_next;
   logic [FLUSH_W-1:0] flush_cnt;
   logic [FLUSH_W-1:0] flush_next;
   logic               rs_pend;
   logic               rt_pend;
   logic               rd_pend;
   logic               any_pend;
   logic               hazard;
   logic               sb_set;
   logic               stall_inc;

   reg_scoreboard u_sb (
      .clock    (clock),
      .reset    (reset),
      .set_en   (sb_set),
      .set_idx  (id_rd),
      .clr_en   (wb_en),
      .clr_idx  (wb_rd),
      .rs_idx   (id_rs),
      .rt_idx   (id_rt),
      .rd_idx   (id_rd),
      .rs_pend  (rs_pend),
      .rt_pend  (rt_pend),
      .rd_pend  (rd_pend),
      .any_pend (any_pend),
      .sb_err   (sb_err)
   );

   assign hazard = id_valid & ((op_reads_rs(id_op) & rs_pend) |
                               (op_reads_rt(id_op) & rt_pend) |
                               (op_writes_rd(id_op) & rd_pend));

   assign sb_set = issue & op_writes_rd(id_op);
   assign halted = (state == ST_HALTED);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_RUN;
         flush_cnt   <= '0;
         stall_count <= '0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_next;
         if (stall_inc && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_W'(1);
      end
   end

   // A taken branch outside FLUSH suppresses the wrong-path decode instruction
   // and bubbles ID/EX; the FLUSH state then covers the following cycles.
   always_comb begin
      state_next   = state;
      flush_next   = flush_cnt;
      issue        = 1'b0;
      pc_stall     = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      stall_inc    = 1'b0;
      if (!reset) begin
         unique case (state)
            ST_HALTED: begin
               pc_stall     = 1'b1;
               if_id_hold   = 1'b1;
               id_ex_bubble = 1'b1;
            end
            ST_FLUSH: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (branch_taken) begin
                  flush_next = FLUSH_LOAD;
               end else if (flush_cnt <= FLUSH_W'(1)) begin
                  state_next = ST_RUN;
                  flush_next = '0;
               end else begin
                  flush_next = flush_cnt - FLUSH_W'(1);
               end
            end
            ST_DRAIN: begin
               if (branch_taken) begin
                  id_ex_bubble = 1'b1;
                  state_next   = ST_FLUSH;
                  flush_next   = FLUSH_LOAD;
               end else begin
                  pc_stall     = 1'b1;
                  if_id_hold   = 1'b1;
                  id_ex_bubble = 1'b1;
                  if (!any_pend) state_next = ST_HALTED;
               end
            end
            default: begin
               if (branch_taken) begin
                  id_ex_bubble = 1'b1;
                  state_next   = ST_FLUSH;
                  flush_next   = FLUSH_LOAD;
               end else if (hazard) begin
                  pc_stall     = 1'b1;
                  if_id_hold   = 1'b1;
                  id_ex_bubble = 1'b1;
                  stall_inc    = 1'b1;
                  state_next   = ST_STALL;
               end else begin
                  issue      = id_valid;
                  state_next = (id_valid && (id_op == OP_HALT)) ? ST_DRAIN : ST_RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int FLUSH_N = 2;
   localparam int CW      = 16;
   localparam int CNT_SAT = 65535;

   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_LI   = 2;
   localparam int OP_MOVE = 3;
   localparam int OP_HALT = 13;
   localparam int OP_NOP  = 14;

   logic          clock = 1'b0;
   logic          reset;
   logic          id_valid;
   logic [5:0]    id_op;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic          wb_en;
   logic [4:0]    wb_rd;
   logic          branch_taken;
   logic          issue, pc_stall, if_id_hold, if_id_flush, id_ex_bubble, halted, sb_err;
   logic [CW-1:0] stall_count;

   int n_vec = 0;
   int n_bad = 0;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_N), .CNT_W(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_op        (id_op),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rd        (id_rd),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .branch_taken (branch_taken),
      .issue        (issue),
      .pc_stall     (pc_stall),
      .if_id_hold   (if_id_hold),
      .if_id_flush  (if_id_flush),
      .id_ex_bubble (id_ex_bubble),
      .halted       (halted),
      .sb_err       (sb_err),
      .stall_count  (stall_count)
   );

   always #5 clock = ~clock;

   // Opcode classes written straight from the ISA description.
   function automatic bit is_writer(input logic [5:0] op);
      return (int'(op) <= 12) && (int'(op) != 8) && (int'(op) != 9);
   endfunction
   function automatic bit uses_rs(input logic [5:0] op);
      return (is_writer(op) && int'(op) != OP_LI) || int'(op) == 8 || int'(op) == 9;
   endfunction
   function automatic bit uses_rt(input logic [5:0] op);
      return int'(op) inside {0, 1, 5, 6, 7, 8, 9, 10, 11, 12};
   endfunction

   // Behavioural model: pending set, flush countdown, drain/halt flags, counter.
   bit m_pend[32];
   int m_flush, m_cnt;
   bit m_drain, m_halt, m_err, m_haz;
   bit e_issue, e_pcs, e_flush, e_bub;

   function automatic void model_outputs();
      m_haz = id_valid && ((uses_rs(id_op) && m_pend[id_rs]) ||
                           (uses_rt(id_op) && m_pend[id_rt]) ||
                           (is_writer(id_op) && m_pend[id_rd]));
      e_issue = 0; e_pcs = 0; e_flush = 0; e_bub = 0;
      if (reset) begin
      end else if (m_halt)        begin e_pcs = 1; e_bub = 1; end
      else if (m_flush > 0)       begin e_flush = 1; e_bub = 1; end
      else if (branch_taken)      e_bub = 1;
      else if (m_drain || m_haz)  begin e_pcs = 1; e_bub = 1; end
      else                        e_issue = id_valid;
   endfunction

   function automatic void model_update();
      bit any;
      if (reset) begin
         foreach (m_pend[i]) m_pend[i] = 0;
         m_flush = 0; m_cnt = 0; m_drain = 0; m_halt = 0; m_err = 0;
         return;
      end
      any = 0;
      foreach (m_pend[i]) any |= m_pend[i];
      if (wb_en && !m_pend[wb_rd]) m_err = 1;
      if (wb_en) m_pend[wb_rd] = 0;
      if (e_issue && is_writer(id_op)) m_pend[id_rd] = 1;
      if (m_halt) begin
      end else if (branch_taken) begin m_flush = FLUSH_N; m_drain = 0; end
      else if (m_flush > 0) m_flush--;
      else if (m_drain) begin if (!any) begin m_halt = 1; m_drain = 0; end end
      else if (m_haz) begin if (m_cnt < CNT_SAT) m_cnt++; end
      else if (e_issue && int'(id_op) == OP_HALT) m_drain = 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int v, input int op, input int rs, input int rt, input int rd,
                        input int we, input int wr, input int br, input int rst);
      id_valid = 1'(v); id_op = 6'(op); id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
      wb_en = 1'(we); wb_rd = 5'(wr); branch_taken = 1'(br); reset = 1'(rst);
   endtask

   // One clock: compare against the model at the falling edge, advance it at the rising edge.
   task automatic step(input bit do_check);
      @(negedge clock);
      model_outputs();
      if (do_check) begin
         check("issue",        32'(issue),        32'(e_issue));
         check("pc_stall",     32'(pc_stall),     32'(e_pcs));
         check("if_id_hold",   32'(if_id_hold),   32'(e_pcs));
         check("if_id_flush",  32'(if_id_flush),  32'(e_flush));
         check("id_ex_bubble", 32'(id_ex_bubble), 32'(e_bub));
         check("halted",       32'(halted),       32'(m_halt));
         check("sb_err",       32'(sb_err),       32'(m_err));
         check("stall_count",  32'(stall_count),  32'(m_cnt));
      end
      @(posedge clock);
      model_update();
      #1;
   endtask

   typedef struct {
      int v, op, rs, rt, rd, we, wr, br;
      int e_iss, e_pcs, e_fl, e_bub, e_hlt, e_cnt;
   } vec_t;

   function automatic vec_t mk(int v, int op, int rs, int rt, int rd, int we, int wr, int br,
                               int iss, int pcs, int fl, int bub, int hlt, int cnt);
      vec_t r;
      r.v = v; r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.we = we; r.wr = wr; r.br = br;
      r.e_iss = iss; r.e_pcs = pcs; r.e_fl = fl; r.e_bub = bub; r.e_hlt = hlt; r.e_cnt = cnt;
      return r;
   endfunction

   vec_t tbl[19];

   initial begin
      // RAW stall on r3, LI/MOVE back-to-back, WAW on r7, branch flush, HALT drain.
      tbl[0]  = mk(1, OP_ADD,  1, 2, 3, 0, 0, 0,  1, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, OP_SUB,  3, 5, 4, 0, 0, 0,  0, 1, 0, 1, 0, 0);
      tbl[2]  = mk(1, OP_SUB,  3, 5, 4, 0, 0, 0,  0, 1, 0, 1, 0, 1);
      tbl[3]  = mk(1, OP_SUB,  3, 5, 4, 1, 3, 0,  0, 1, 0, 1, 0, 2);
      tbl[4]  = mk(1, OP_SUB,  3, 5, 4, 0, 0, 0,  1, 0, 0, 0, 0, 3);
      tbl[5]  = mk(1, OP_LI,   0, 0, 7, 0, 0, 0,  1, 0, 0, 0, 0, 3);
      tbl[6]  = mk(1, OP_MOVE, 9, 4, 8, 0, 0, 0,  1, 0, 0, 0, 0, 3);
      tbl[7]  = mk(1, OP_LI,   0, 0, 7, 0, 0, 0,  0, 1, 0, 1, 0, 3);
      tbl[8]  = mk(1, OP_LI,   0, 0, 7, 0, 0, 1,  0, 0, 0, 1, 0, 4);
      tbl[9]  = mk(1, OP_LI,   0, 0, 7, 0, 0, 0,  0, 0, 1, 1, 0, 4);
      tbl[10] = mk(1, OP_LI,   0, 0, 7, 0, 0, 0,  0, 0, 1, 1, 0, 4);
      tbl[11] = mk(1, OP_LI,   0, 0, 7, 0, 0, 0,  0, 1, 0, 1, 0, 4);
      tbl[12] = mk(0, OP_NOP,  0, 0, 0, 1, 7, 0,  0, 0, 0, 0, 0, 5);
      tbl[13] = mk(1, OP_HALT, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5);
      tbl[14] = mk(0, OP_NOP,  0, 0, 0, 1, 4, 0,  0, 1, 0, 1, 0, 5);
      tbl[15] = mk(0, OP_NOP,  0, 0, 0, 1, 8, 0,  0, 1, 0, 1, 0, 5);
      tbl[16] = mk(0, OP_NOP,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 5);
      tbl[17] = mk(1, OP_ADD,  1, 2, 3, 0, 0, 1,  0, 1, 0, 1, 1, 5);
      tbl[18] = mk(1, OP_ADD,  1, 2, 3, 0, 0, 1,  0, 1, 0, 1, 1, 5);

      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1);
      step(0);
      step(1);

      // Directed table.
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd,
               tbl[i].we, tbl[i].wr, tbl[i].br, 0);
         @(negedge clock);
         model_outputs();
         check($sformatf("tbl%0d.issue", i),    32'(issue),        32'(tbl[i].e_iss));
         check($sformatf("tbl%0d.pc_stall", i), 32'(pc_stall),     32'(tbl[i].e_pcs));
         check($sformatf("tbl%0d.hold", i),     32'(if_id_hold),   32'(tbl[i].e_pcs));
         check($sformatf("tbl%0d.flush", i),    32'(if_id_flush),  32'(tbl[i].e_fl));
         check($sformatf("tbl%0d.bubble", i),   32'(id_ex_bubble), 32'(tbl[i].e_bub));
         check($sformatf("tbl%0d.halted", i),   32'(halted),       32'(tbl[i].e_hlt));
         check($sformatf("tbl%0d.sb_err", i),   32'(sb_err),       32'(0));
         check($sformatf("tbl%0d.count", i),    32'(stall_count),  32'(tbl[i].e_cnt));
         @(posedge clock);
         model_update();
         #1;
      end

      // Write-back to a register never issued sets a sticky error.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1); step(1);
      drive(0, OP_NOP, 0, 0, 0, 1, 12, 0, 0); step(1);
      drive(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0); step(1);
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0); step(1);
      check("sb_err_sticky", 32'(sb_err), 32'(1));

      // Reset in the middle of DRAIN.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1); step(1);
      drive(1, OP_LI, 0, 0, 5, 0, 0, 0, 0);  step(1);
      drive(1, OP_HALT, 0, 0, 0, 0, 0, 0, 0); step(1);
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0); step(1);
      check("drain_pc_stall", 32'(pc_stall), 32'(1));
      drive(1, OP_ADD, 1, 2, 3, 0, 0, 0, 1); #1;
      check("rst_comb_bubble", 32'(id_ex_bubble), 32'(0));
      step(1);
      drive(1, OP_LI, 0, 0, 5, 0, 0, 0, 0); #1;
      check("rst_drain_issue", 32'(issue), 32'(1));
      check("rst_drain_halted", 32'(halted), 32'(0));
      step(1);

      // Taken branch aborts a drain; r5 stays pending through the flush.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1); step(1);
      drive(1, OP_LI, 0, 0, 5, 0, 0, 0, 0);  step(1);
      drive(1, OP_HALT, 0, 0, 0, 0, 0, 0, 0); step(1);
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0); step(1);
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 1, 0); step(1);
      drive(1, OP_NOP, 0, 0, 0, 0, 0, 0, 0); step(1);
      check("abort_flush", 32'(if_id_flush), 32'(1));
      step(1);
      check("abort_halted", 32'(halted), 32'(0));
      drive(1, OP_LI, 0, 0, 5, 0, 0, 0, 0); #1;
      check("abort_waw_r5", 32'(pc_stall), 32'(1));
      step(1);

      // Branch while already flushing restarts the countdown.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 1, 0); step(1);
      step(1);
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0); step(1);
      step(1);
      check("restart_flush_tail", 32'(if_id_flush), 32'(0));

      // Long hazard saturates the stall counter.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1); step(1);
      drive(1, OP_LI, 0, 0, 1, 0, 0, 0, 0);  step(1);
      for (int i = 0; i < 70000; i++) step(0);
      check("stall_sat", 32'(stall_count), 32'(16'hFFFF));
      step(1);

      // Randomized traffic against the model.
      drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1); step(1);
      for (int i = 0; i < 3000; i++) begin
         drive(int'($urandom_range(0, 9) != 0), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 59) == 0));
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the IF/ID/EX/WB instruction pipeline. It tracks in-flight register writes in a 32-entry scoreboard and stalls the fetch and decode stages on read-after-write and write-after-write hazards. It squashes wrong-path instructions on a taken branch and drains the pipeline to a halted state on the HALT opcode. It sits beside the decode stage and drives PC hold, IF/ID hold/flush and ID/EX bubble insertion.

## Interface
Parameters:
- FLUSH_CYCLES, 2, cycles of IF/ID flush + ID/EX bubble after a taken branch (1..7)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clock  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  IF/ID holds a real instruction
- id_op  in  6  opcode of instruction in decode (IF_ID[31:26])
- id_rs / id_rt / id_rd  in  5 each  register fields ([25:21], [20:16], [15:11])
- wb_en  in  1  write-back this cycle (EX/WB write flag)
- wb_rd  in  5  write-back destination
- branch_taken  in  1  branch resolved taken in EX this cycle
- issue  out  1  decode instruction advances to ID/EX this cycle
- pc_stall  out  1  hold PC
- if_id_hold  out  1  hold IF/ID register
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP control (16'h4000) into ID/EX
- halted  out  1  pipeline stopped, sticky until reset
- sb_err  out  1  sticky: write-back to a register not marked pending
- stall_count  out  CNT_W  saturating count of hazard-stall cycles

## Operation
- Opcode classes (shared package): writers rd = 000000–001100 except 001000/001001; read rs = all writers except LI (000010), plus BEQ/BNE; read rt = ADD, SUB, SLL, SRL, AND, OR, XOR, MUL, BEQ, BNE; MOVE and ADDI read rs only. HALT = 001101. NOP = 001110. Opcodes 001111–111111 behave as NOP. r0 is an ordinary register.
- Scoreboard pending[31:0]: set pending[id_rd] on issue of a writer. Clear pending[wb_rd] on wb_en. On a simultaneous set and clear of the same index, set wins. wb_en with pending[wb_rd]=0 sets sb_err.
- Hazard = id_valid & (read rs & pending[rs] | read rt & pending[rt] | writer & pending[rd]). Uses the registered pending value, so a register written back at edge N is readable by decode only in cycle N+1.
- FSM states:
  - RUN: decode instruction issues unless hazard. A hazard goes to STALL. A HALT issue goes to DRAIN.
  - STALL: pc_stall=if_id_hold=id_ex_bubble=1 and stall_count increments while the hazard holds. Returns to RUN in the cycle the hazard clears; issue is asserted in that same cycle.
  - FLUSH: entered from any non-HALTED state on branch_taken. Lasts FLUSH_CYCLES cycles with if_id_flush=id_ex_bubble=1 and issue=0. Exits to RUN.
  - DRAIN: issue=0, pc_stall=if_id_hold=id_ex_bubble=1 until pending==0. Then goes to HALTED.
  - HALTED: same outputs as DRAIN plus halted=1. Only reset exits.
- Priority: reset > HALTED > branch_taken > DRAIN > hazard > issue.
- branch_taken in DRAIN aborts the halt and goes to FLUSH, because the HALT was on the wrong path.

## Timing
- FSM, scoreboard, flush counter, sb_err and stall_count are registered.
- issue, pc_stall, if_id_hold, if_id_flush and id_ex_bubble are combinational from state and current inputs, so a stall takes effect in the cycle the hazard is presented.
- Reset values: state=RUN, pending=0, flush counter=0, halted=0, sb_err=0, stall_count=0.
- Combinational outputs under reset: all 0.
- Reset asserted mid-FLUSH/STALL/DRAIN returns to RUN on the next edge with the scoreboard cleared.
- branch_taken while already in FLUSH restarts the counter at FLUSH_CYCLES.
- stall_count saturates at all-ones and never wraps.

## Structure
- Package pipe_pkg holds opcode constants, the 16-bit one-hot control constants (NOP=16'h4000), the FSM state enum, and the functions op_writes_rd, op_reads_rs and op_reads_rt.
- One sub-module, reg_scoreboard: the 32-bit pending array with set/clear ports, the three lookup outputs and the sb_err flag.
- The FSM and counters live in pipeline_hazard_ctrl.

## Test plan
- ADD r3←r1,r2 issues at cycle 0. Next instruction SUB r4←r3,r5 → STALL with pc_stall=1 until wb_en with wb_rd=3 at edge N. SUB issues at cycle N+1. stall_count equals the stall cycles.
- LI r7 then MOVE r8←r9 back-to-back → no stall; issue=1 both cycles. LI followed by LI to the same rd → WAW stall until r7 write-back.
- branch_taken during a hazard stall → FLUSH for exactly 2 cycles with if_id_flush=id_ex_bubble=1. Pending bits stay set. Back to RUN afterwards.
- HALT issued with r5 pending → DRAIN. halted=1 only in the cycle after wb_rd=5 retires and stays 1 under further id_valid activity.
- HALT in DRAIN followed by branch_taken → FLUSH, halted stays 0. Reset asserted mid-DRAIN → next cycle state RUN, pending=0, all outputs at reset values.
- wb_en with wb_rd=12 never issued → sb_err=1 and sticky. Hold a hazard for 70000 cycles with CNT_W=16 → stall_count=16'hFFFF.
